// File: rtl/sprite_pkg.sv
// Shared types and default sizing for the sprite layer scheduler.
// Struct field widths follow the default sheet geometry.
package sprite_pkg;

  localparam int NUM_SPRITES_DEF = 4;
  localparam int WIDTH_DEF       = 256;
  localparam int HEIGHT_DEF      = 256;
  localparam int NUM_FRAMES_DEF  = 2;
  localparam int ROM_LATENCY_DEF = 2;

  localparam int ID_W    = $clog2(NUM_SPRITES_DEF);
  localparam int ADDR_W  = $clog2(NUM_FRAMES_DEF * WIDTH_DEF * HEIGHT_DEF);
  localparam int FRAME_W = (NUM_FRAMES_DEF > 1) ? $clog2(NUM_FRAMES_DEF) : 1;

  typedef struct packed {
    logic               en;
    logic [10:0]        x;
    logic [9:0]         y;
    logic [FRAME_W-1:0] frame;
  } sprite_cfg_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sprite_hit_priority.sv
// Per-slot coverage test on the active registers and lowest-index priority select.
// Purely combinational; outputs the winning slot and its full sheet address.
module sprite_hit_priority
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HEIGHT      = HEIGHT_DEF,
  parameter int IDW         = ID_W,
  parameter int AW          = ADDR_W
) (
  input  sprite_cfg_t       cfg_i [NUM_SPRITES],
  input  logic [10:0]       hcount_i,
  input  logic [9:0]        vcount_i,
  output logic              hit_o,
  output logic [IDW-1:0]    id_o,
  output logic [AW-1:0]     addr_o
);

  logic [NUM_SPRITES-1:0] slot_hit;
  logic [AW-1:0]          slot_addr [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    logic [11:0] x_end;
    logic [10:0] y_end;
    logic [10:0] dh;
    logic [9:0]  dv;

    // One extra bit on the far edge so sprites at the right/bottom clip instead of wrapping.
    assign x_end = {1'b0, cfg_i[g].x} + 12'(WIDTH);
    assign y_end = {1'b0, cfg_i[g].y} + 11'(HEIGHT);
    assign dh    = hcount_i - cfg_i[g].x;
    assign dv    = vcount_i - cfg_i[g].y;

    assign slot_hit[g] = cfg_i[g].en
                       && (hcount_i >= cfg_i[g].x) && ({1'b0, hcount_i} < x_end)
                       && (vcount_i >= cfg_i[g].y) && ({1'b0, vcount_i} < y_end);

    assign slot_addr[g] = AW'(cfg_i[g].frame) * AW'(WIDTH * HEIGHT)
                        + (AW'(dv) << $clog2(WIDTH))
                        + AW'(dh);
  end

  always_comb begin
    hit_o  = 1'b0;
    id_o   = '0;
    addr_o = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_o  = 1'b1;
        id_o   = IDW'(i);
        addr_o = slot_addr[i];
      end
    end
  end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// Time-shares one sheet ROM between sprite slots; shadow config commits to active in vblank.
// Latency hcount/vcount -> pixel_out is 1 + ROM_LATENCY + 1; config stalls only during COMMIT.
module sprite_layer_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HEIGHT      = HEIGHT_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic                                      pixel_clk_in,
  input  logic                                      rst_n_in,
  input  logic [10:0]                               hcount_in,
  input  logic [9:0]                                vcount_in,
  input  logic                                      frame_start_in,
  input  logic                                      cfg_valid_in,
  output logic                                      cfg_ready_out,
  input  logic [$clog2(NUM_SPRITES)-1:0]            cfg_id_in,
  input  logic [10:0]                               cfg_x_in,
  input  logic [9:0]                                cfg_y_in,
  input  logic [$clog2(NUM_FRAMES)-1:0]             cfg_frame_in,
  input  logic                                      cfg_en_in,
  output logic                                      pending_out,
  output logic [$clog2(NUM_FRAMES*WIDTH*HEIGHT)-1:0] rom_addr_out,
  input  logic [11:0]                               rom_data_in,
  output logic [11:0]                               pixel_out,
  output logic                                      in_sprite_out,
  output logic [$clog2(NUM_SPRITES)-1:0]            sprite_id_out
);

  localparam int IDW = $clog2(NUM_SPRITES);
  localparam int AW  = $clog2(NUM_FRAMES * WIDTH * HEIGHT);

  sprite_cfg_t  shadow_q [NUM_SPRITES];
  sprite_cfg_t  active_q [NUM_SPRITES];
  sched_state_t state_q;
  logic [IDW-1:0] idx_q;
  logic           ready_q;
  logic           pending_q;

  logic           cfg_wr;
  sprite_cfg_t    cfg_d;

  logic           win_hit;
  logic [IDW-1:0] win_id;
  logic [AW-1:0]  win_addr;

  logic [AW-1:0]          rom_addr_q, rom_addr_d;
  logic                   hit0_q;
  logic [IDW-1:0]         id0_q;
  logic [ROM_LATENCY-1:0] hit_dly_q;
  logic [IDW-1:0]         id_dly_q [ROM_LATENCY];
  logic [11:0]            pixel_q, pixel_d;
  logic                   in_sprite_q;
  logic [IDW-1:0]         sprite_id_q;

  assign cfg_wr = cfg_valid_in && ready_q;

  always_comb begin
    cfg_d       = '0;
    cfg_d.en    = cfg_en_in;
    cfg_d.x     = cfg_x_in;
    cfg_d.y     = cfg_y_in;
    cfg_d.frame = FRAME_W'(cfg_frame_in);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
    end else if (cfg_wr) begin
      shadow_q[cfg_id_in] <= cfg_d;
    end
  end

  // A write accepted alongside frame_start lands in shadow on the same edge that
  // enters COMMIT, so the first copy already sees it.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_wr) pending_q <= 1'b1;
          if (frame_start_in && (pending_q || cfg_wr)) begin
            state_q <= COMMIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        COMMIT: begin
          active_q[idx_q] <= shadow_q[idx_q];
          idx_q           <= idx_q + 1'b1;
          if (idx_q == IDW'(NUM_SPRITES - 1)) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  sprite_hit_priority #(
    .NUM_SPRITES (NUM_SPRITES),
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .IDW         (IDW),
    .AW          (AW)
  ) u_hit (
    .cfg_i    (active_q),
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .hit_o    (win_hit),
    .id_o     (win_id),
    .addr_o   (win_addr)
  );

  assign rom_addr_d = win_hit ? win_addr : rom_addr_q;
  assign pixel_d    = hit_dly_q[ROM_LATENCY-1] ? rom_data_in : 12'h000;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rom_addr_q  <= '0;
      hit0_q      <= 1'b0;
      id0_q       <= '0;
      hit_dly_q   <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) id_dly_q[i] <= '0;
      pixel_q     <= '0;
      in_sprite_q <= 1'b0;
      sprite_id_q <= '0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      hit0_q       <= win_hit;
      id0_q        <= win_id;
      hit_dly_q[0] <= hit0_q;
      id_dly_q[0]  <= id0_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        hit_dly_q[i] <= hit_dly_q[i-1];
        id_dly_q[i]  <= id_dly_q[i-1];
      end
      pixel_q     <= pixel_d;
      in_sprite_q <= hit_dly_q[ROM_LATENCY-1];
      sprite_id_q <= id_dly_q[ROM_LATENCY-1];
    end
  end

  assign cfg_ready_out = ready_q;
  assign pending_out   = pending_q;
  assign rom_addr_out  = rom_addr_q;
  assign pixel_out     = pixel_q;
  assign in_sprite_out = in_sprite_q;
  assign sprite_id_out = sprite_id_q;

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Randomized bench with a rule-level sprite model and a 2-cycle ROM stand-in.
module tb_sprite_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        frame_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_id;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic [0:0]  cfg_frame;
  logic        cfg_en;
  logic        pending;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] pixel;
  logic        in_sprite;
  logic [1:0]  sprite_id;
  logic [16:0] rd1;

  int total = 0;
  int bad   = 0;

  typedef struct { int en; int x; int y; int fr; } cfg_m_t;
  cfg_m_t sh_m [4];
  cfg_m_t act_m [4];
  int     last_addr_m;

  always #5 clk = ~clk;

  sprite_layer_scheduler dut (
    .pixel_clk_in   (clk),
    .rst_n_in       (rst_n),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .frame_start_in (frame_start),
    .cfg_valid_in   (cfg_valid),
    .cfg_ready_out  (cfg_ready),
    .cfg_id_in      (cfg_id),
    .cfg_x_in       (cfg_x),
    .cfg_y_in       (cfg_y),
    .cfg_frame_in   (cfg_frame),
    .cfg_en_in      (cfg_en),
    .pending_out    (pending),
    .rom_addr_out   (rom_addr),
    .rom_data_in    (rom_data),
    .pixel_out      (pixel),
    .in_sprite_out  (in_sprite),
    .sprite_id_out  (sprite_id)
  );

  function automatic logic [11:0] rom_f(int a);
    return 12'((a * 37 + 5) ^ (a >>> 5));
  endfunction

  // Two-stage sheet ROM: address registered, then data registered.
  always @(posedge clk) begin
    rd1      <= rom_addr;
    rom_data <= rom_f(int'(rd1));
  end

  function automatic int model_win(int h, int v, output int addr);
    addr = 0;
    for (int i = 0; i < 4; i++) begin
      if (act_m[i].en != 0 && h >= act_m[i].x && h < act_m[i].x + 256 &&
          v >= act_m[i].y && v < act_m[i].y + 256) begin
        addr = act_m[i].fr * 65536 + (v - act_m[i].y) * 256 + (h - act_m[i].x);
        return i;
      end
    end
    return -1;
  endfunction

  function automatic int clampi(int val, int lo, int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  task automatic cfg_write(int id, int x, int y, int fr, int en);
    int waited = 0;
    cfg_valid = 1'b1;
    cfg_id = 2'(id); cfg_x = 11'(x); cfg_y = 10'(y); cfg_frame = 1'(fr); cfg_en = 1'(en);
    while (cfg_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 50) begin
      bad++; total++;
      $display("FAIL cfg_write_timeout ready=%b required=1", cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    sh_m[id] = '{en, x, y, fr};
  endtask

  // Pulses frame_start and reports how many cycles cfg_ready stayed low.
  task automatic pulse_commit(output int low_cycles);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    low_cycles = 0;
    while (cfg_ready === 1'b0 && low_cycles < 20) begin
      low_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_pixel(int h, int v, output int w, output int a);
    hcount = 11'(h); vcount = 10'(v);
    w = model_win(h, v, a);
    if (w >= 0) last_addr_m = a;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_stream(int n, int mode);
    logic       exp_hit [512];
    logic [1:0] exp_id  [512];
    logic [11:0] exp_pix [512];
    int h, v, w, a, s;
    for (int j = 0; j < n + 3; j++) begin
      if (j < n) begin
        if (mode == 0) begin
          h = $urandom_range(0, 2047); v = $urandom_range(0, 1023);
        end else if (mode == 1) begin
          s = $urandom_range(0, 3);
          h = clampi(act_m[s].x + $urandom_range(0, 300) - 20, 0, 2047);
          v = clampi(act_m[s].y + $urandom_range(0, 300) - 20, 0, 1023);
        end else if ($urandom_range(0, 1) == 0) begin
          h = $urandom_range(0, 255); v = $urandom_range(0, 255);
        end else begin
          h = $urandom_range(1990, 2047); v = $urandom_range(990, 1023);
        end
        hcount = 11'(h); vcount = 10'(v);
        w = model_win(h, v, a);
        exp_hit[j] = (w >= 0);
        exp_id[j]  = (w >= 0) ? 2'(w) : 2'd0;
        exp_pix[j] = (w >= 0) ? rom_f(a) : 12'h000;
        if (w >= 0) last_addr_m = a;
      end
      @(posedge clk); #1;
      if (j < n) begin
        total++;
        if (rom_addr !== 17'(last_addr_m)) begin
          bad++; $display("FAIL stream_rom_addr j=%0d got=%0d exp=%0d", j, rom_addr, last_addr_m);
        end
      end
      if (j >= 3) begin
        total++;
        if (in_sprite !== exp_hit[j-3] || pixel !== exp_pix[j-3] || sprite_id !== exp_id[j-3]) begin
          bad++;
          $display("FAIL stream_pixel j=%0d got hit=%b pix=%h id=%0d exp hit=%b pix=%h id=%0d",
                   j - 3, in_sprite, pixel, sprite_id, exp_hit[j-3], exp_pix[j-3], exp_id[j-3]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cfg_ready !== 1'b1 || pending !== 1'b0 || rom_addr !== 17'd0 || pixel !== 12'd0 ||
        in_sprite !== 1'b0 || sprite_id !== 2'd0) begin
      bad++; $display("FAIL reset_held ready=%b pend=%b addr=%0d pix=%h hit=%b id=%0d",
                      cfg_ready, pending, rom_addr, pixel, in_sprite, sprite_id);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (cfg_ready !== 1'b1 || pending !== 1'b0 || in_sprite !== 1'b0) begin
      bad++; $display("FAIL reset_release ready=%b pend=%b hit=%b", cfg_ready, pending, in_sprite);
    end
    test_stream(60, 0);
  endtask

  task automatic test_pending_commit();
    int w, a, lc;
    cfg_write(0, 100, 50, 1, 1);
    total++;
    if (pending !== 1'b1) begin bad++; $display("FAIL pending_set got=%b exp=1", pending); end
    drive_pixel(100, 50, w, a);
    total++;
    if (in_sprite !== 1'b0) begin bad++; $display("FAIL uncommitted_hit got=%b exp=0", in_sprite); end
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    total++;
    if (lc != 4 || pending !== 1'b0) begin
      bad++; $display("FAIL commit_len got=%0d pend=%b exp=4 pend=0", lc, pending);
    end
    hcount = 11'd100; vcount = 10'd50; last_addr_m = 65536;
    @(posedge clk); #1;
    total++;
    if (rom_addr !== 17'd65536) begin bad++; $display("FAIL first_addr got=%0d exp=65536", rom_addr); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (pixel !== rom_f(65536) || in_sprite !== 1'b1 || sprite_id !== 2'd0) begin
      bad++; $display("FAIL first_pixel got pix=%h hit=%b id=%0d exp pix=%h hit=1 id=0",
                      pixel, in_sprite, sprite_id, rom_f(65536));
    end
  endtask

  task automatic test_priority();
    int w, a, lc;
    cfg_write(2, 110, 40, 0, 1);
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    drive_pixel(120, 60, w, a);
    total++;
    if (sprite_id !== 2'd0 || in_sprite !== 1'b1 || pixel !== rom_f(65536 + 10 * 256 + 20)) begin
      bad++; $display("FAIL priority_slot0 got id=%0d hit=%b pix=%h exp id=0", sprite_id, in_sprite, pixel);
    end
    cfg_write(0, 100, 50, 1, 0);
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    drive_pixel(120, 60, w, a);
    total++;
    if (sprite_id !== 2'd2 || in_sprite !== 1'b1 || pixel !== rom_f(20 * 256 + 10)) begin
      bad++; $display("FAIL priority_slot2 got id=%0d hit=%b pix=%h exp id=2", sprite_id, in_sprite, pixel);
    end
    test_stream(80, 1);
  endtask

  task automatic test_back_to_back();
    int lc, stall;
    // Write accepted in the same cycle as frame_start joins that commit.
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL same_cycle_ready got=%b exp=1", cfg_ready); end
    cfg_valid = 1'b1; frame_start = 1'b1;
    cfg_id = 2'd1; cfg_x = 11'd300; cfg_y = 10'd300; cfg_frame = 1'b1; cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; frame_start = 1'b0;
    sh_m[1] = '{1, 300, 300, 1};
    lc = 0;
    while (cfg_ready === 1'b0 && lc < 20) begin lc++; @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    total++;
    if (lc != 4 || pending !== 1'b0) begin
      bad++; $display("FAIL same_cycle_commit got len=%0d pend=%b exp len=4 pend=0", lc, pending);
    end
    test_stream(60, 1);
    // Write presented during COMMIT waits for ready and stays in shadow only.
    cfg_write(3, 500, 200, 0, 1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    cfg_valid = 1'b1;
    cfg_id = 2'd2; cfg_x = 11'd140; cfg_y = 10'd20; cfg_frame = 1'b1; cfg_en = 1'b1;
    stall = 0;
    while (cfg_ready === 1'b0 && stall < 20) begin stall++; @(posedge clk); #1; end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    sh_m[2] = '{1, 140, 20, 1};
    total++;
    if (stall != 4 || pending !== 1'b1) begin
      bad++; $display("FAIL stalled_write got stall=%0d pend=%b exp stall=4 pend=1", stall, pending);
    end
    test_stream(60, 1);
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    test_stream(80, 1);
  endtask

  task automatic test_edge_clip();
    int w, a, lc;
    cfg_write(0, 0, 0, 0, 0);
    cfg_write(1, 0, 0, 0, 0);
    cfg_write(2, 0, 0, 0, 0);
    cfg_write(3, 2000, 1000, 1, 1);
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    drive_pixel(2047, 1023, w, a);
    total++;
    if (in_sprite !== 1'b1 || sprite_id !== 2'd3 || pixel !== rom_f(65536 + 23 * 256 + 47)) begin
      bad++; $display("FAIL edge_corner got hit=%b id=%0d pix=%h exp hit=1 id=3", in_sprite, sprite_id, pixel);
    end
    drive_pixel(20, 10, w, a);
    total++;
    if (in_sprite !== 1'b0) begin bad++; $display("FAIL edge_nowrap got=%b exp=0", in_sprite); end
    test_stream(200, 2);
  endtask

  task automatic test_random();
    int lc;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 4; s++)
        cfg_write(s, $urandom_range(0, 2047), $urandom_range(0, 1023),
                  $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0);
      pulse_commit(lc);
      for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
      total++;
      if (lc != 4) begin bad++; $display("FAIL random_commit_len got=%0d exp=4", lc); end
      test_stream(250, 1);
      test_stream(80, 0);
    end
  endtask

  task automatic test_reset_mid_commit();
    int lc;
    for (int s = 0; s < 4; s++) cfg_write(s, 40 * s, 30 * s, s & 1, 1);
    pulse_commit(lc);
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    cfg_write(1, 600, 600, 0, 1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin sh_m[i] = '{0, 0, 0, 0}; act_m[i] = '{0, 0, 0, 0}; end
    last_addr_m = 0;
    total++;
    if (cfg_ready !== 1'b1 || pending !== 1'b0 || rom_addr !== 17'd0 || pixel !== 12'd0 ||
        in_sprite !== 1'b0 || sprite_id !== 2'd0) begin
      bad++; $display("FAIL reset_mid_commit ready=%b pend=%b addr=%0d pix=%h hit=%b id=%0d",
                      cfg_ready, pending, rom_addr, pixel, in_sprite, sprite_id);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_commit(lc);
    total++;
    if (lc != 0 || pending !== 1'b0) begin
      bad++; $display("FAIL idle_frame_start got len=%0d pend=%b exp len=0 pend=0", lc, pending);
    end
    test_stream(100, 1);
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; frame_start = 1'b0; cfg_valid = 1'b0;
    cfg_id = '0; cfg_x = '0; cfg_y = '0; cfg_frame = '0; cfg_en = 1'b0;
    for (int i = 0; i < 4; i++) begin sh_m[i] = '{0, 0, 0, 0}; act_m[i] = '{0, 0, 0, 0}; end
    last_addr_m = 0;
    test_reset();
    test_pending_commit();
    test_priority();
    test_back_to_back();
    test_edge_clip();
    test_random();
    test_reset_mid_commit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
